// File: rtl/vec_rd_pkg.sv
// Shared types and defaults for the vector-memory read-port scheduler.
package vec_rd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_AW = 32;
  localparam int DEF_LW = 8;

  // Requester-id width; a single requester still needs one bit of owner tag.
  function automatic int owner_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vec_rd_scheduler_burst_counter.sv
// Loadable AW-bit up-counter used as the burst word-address generator.
module burst_counter #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          en,
  output logic [AW-1:0] out
);

  // Load wins over count; the address wraps naturally at 2^AW.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out <= '0;
    end else if (load) begin
      out <= load_val;
    end else if (en) begin
      out <= out + AW'(1);
    end
  end

endmodule

// File: rtl/vec_rd_scheduler.sv
// Round-robin burst read scheduler: grants one requester, then walks its
// burst through the single synchronous-read vector memory port.
module vec_rd_scheduler
  import vec_rd_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = DEF_AW,
  parameter int LW   = DEF_LW,
  localparam int OW  = owner_w(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_base,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]    req_ready,
  output logic               mem_rd,
  output logic [AW-1:0]      mem_addr,
  input  logic               mem_stall,
  output logic               rd_valid,
  output logic [OW-1:0]      rd_owner,
  output logic               rd_last,
  output logic [NREQ-1:0]    done,
  output logic               busy
);

  state_t          state;
  state_t          state_nx;
  logic [OW-1:0]   rr_ptr;
  logic [OW-1:0]   owner;
  logic [OW-1:0]   grant;
  logic            grant_vld;
  logic [AW-1:0]   grant_base;
  logic [LW-1:0]   grant_len;
  logic [LW-1:0]   remaining;
  logic            accept;
  logic            issue;
  logic            last_issue;

  // Cyclic search for the first pending requester starting at rr_ptr.
  always_comb begin
    int            idx;
    logic [OW-1:0] idx_w;
    idx        = 0;
    idx_w      = '0;
    grant      = '0;
    grant_vld  = 1'b0;
    grant_base = '0;
    grant_len  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      idx_w = OW'(idx);
      if (!grant_vld && req_valid[idx_w]) begin
        grant_vld = 1'b1;
        grant     = idx_w;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (OW'(k) == grant) begin
        grant_base = req_base[k*AW +: AW];
        grant_len  = req_len[k*LW +: LW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // req_ready is forced low while reset is held so every output reads zero.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    accept    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_vld) begin
          req_ready[grant] = rst;
          accept           = 1'b1;
          if (grant_len != '0) state_nx = BURST;
        end
      end
      BURST: begin
        issue = !mem_stall;
        if (issue && remaining == LW'(1)) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign last_issue = issue && (remaining == LW'(1));
  assign mem_rd     = (state == BURST);
  assign busy       = (state == BURST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      owner     <= '0;
      remaining <= '0;
      rd_valid  <= 1'b0;
      rd_owner  <= '0;
      rd_last   <= 1'b0;
      done      <= '0;
    end else begin
      rd_valid <= issue;
      rd_last  <= last_issue;
      done     <= '0;
      if (issue) begin
        rd_owner  <= owner;
        remaining <= remaining - LW'(1);
      end
      if (last_issue) done[owner] <= 1'b1;
      // Empty bursts complete immediately without touching memory.
      if (accept) begin
        rr_ptr    <= (grant == OW'(NREQ - 1)) ? '0 : grant + OW'(1);
        owner     <= grant;
        remaining <= grant_len;
        if (grant_len == '0) done[grant] <= 1'b1;
      end
    end
  end

  burst_counter #(.AW(AW)) u_addr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && (grant_len != '0)),
    .load_val (grant_base),
    .en       (issue),
    .out      (mem_addr)
  );

endmodule

// File: tb/tb_vec_rd_scheduler.sv
// Self-checking bench for vec_rd_scheduler: directed table, corner sequences
// and randomized traffic scored against a transaction-level model.
module tb_vec_rd_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_base;
  logic [15:0] req_len;
  logic [1:0]  req_ready;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic        mem_stall;
  logic        rd_valid;
  logic        rd_owner;
  logic        rd_last;
  logic [1:0]  done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  vec_rd_scheduler #(.NREQ(2), .AW(32), .LW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_base  (req_base),
    .req_len   (req_len),
    .req_ready (req_ready),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_stall (mem_stall),
    .rd_valid  (rd_valid),
    .rd_owner  (rd_owner),
    .rd_last   (rd_last),
    .done      (done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic setReq(input int who, input logic [31:0] base, input int len);
    if (who == 0) begin
      req_base[31:0] = base;
      req_len[7:0]   = 8'(len);
    end else begin
      req_base[63:32] = base;
      req_len[15:8]   = 8'(len);
    end
  endtask

  // Transaction-level model: an accepted burst becomes a queue of expected
  // addresses; each unstalled beat pops one and predicts next-cycle tagging.
  logic [31:0] addrQ[$];
  int          mOwner;
  int          mRr;
  logic        pendValid;
  int          pendOwner;
  logic        pendLast;
  logic [1:0]  pendDone;

  always @(negedge clk) begin : monitor
    logic [1:0]  expReady;
    logic [1:0]  nDone;
    logic        nValid;
    logic        nLast;
    int          nOwner;
    int          g;
    int          blen;
    logic [31:0] a;
    if (!rst) begin
      checkOutput("reset_outputs",
                  {23'd0, req_ready, mem_rd, mem_addr, rd_valid, rd_owner, rd_last, done, busy}, 64'd0);
      addrQ.delete();
      mRr = 0; mOwner = 0;
      pendValid = 1'b0; pendOwner = 0; pendLast = 1'b0; pendDone = 2'b00;
    end else begin
      expReady = 2'b00;
      g = -1;
      if (addrQ.size() == 0) begin
        for (int k = 0; k < 2; k++) begin
          int idx;
          idx = (mRr + k) % 2;
          if (g < 0 && req_valid[idx] == 1'b1) g = idx;
        end
      end
      if (g >= 0) expReady[g] = 1'b1;
      checkOutput("req_ready", req_ready, expReady);
      checkOutput("busy", busy, addrQ.size() != 0);
      checkOutput("mem_rd", mem_rd, addrQ.size() != 0);
      checkOutput("rd_valid", rd_valid, pendValid);
      if (pendValid) begin
        checkOutput("rd_owner", rd_owner, pendOwner);
        checkOutput("rd_last", rd_last, pendLast);
      end
      checkOutput("done", done, pendDone);
      nValid = 1'b0; nLast = 1'b0; nOwner = 0; nDone = 2'b00;
      if (addrQ.size() != 0) begin
        checkOutput("mem_addr", mem_addr, addrQ[0]);
        if (!mem_stall) begin
          a = addrQ.pop_front();
          nValid = 1'b1;
          nOwner = mOwner;
          nLast  = (addrQ.size() == 0);
          if (nLast) nDone[mOwner] = 1'b1;
        end
      end else if (g >= 0) begin
        mRr  = (g + 1) % 2;
        blen = (g == 0) ? int'(req_len[7:0]) : int'(req_len[15:8]);
        a    = (g == 0) ? req_base[31:0] : req_base[63:32];
        if (blen == 0) begin
          nDone[g] = 1'b1;
        end else begin
          for (int b = 0; b < blen; b++) begin
            addrQ.push_back(a);
            a = a + 32'd1;
          end
          mOwner = g;
        end
      end
      pendValid = nValid; pendOwner = nOwner; pendLast = nLast; pendDone = nDone;
    end
  end

  typedef struct {
    int          who;
    logic [31:0] base;
    int          len;
    int          stallBeat;
    int          stallCycles;
    logic [31:0] expLast;
    int          expBeats;
    int          expLat;
  } vec_t;

  vec_t vecs[5];

  // Drives one request; latency is counted in cycles from the accept cycle.
  task automatic applyStimulus(input vec_t v, output int beats, output logic [31:0] lastAddr, output int lat);
    bit acc;
    int cyc;
    int stallUsed;
    beats = 0; lastAddr = '0; lat = -1; acc = 0; cyc = 0; stallUsed = 0;
    setReq(v.who, v.base, v.len);
    req_valid[v.who] = 1'b1;
    for (int c = 0; c < 64 && lat < 0; c++) begin
      @(negedge clk);
      if (acc) cyc++;
      else if (req_ready[v.who]) acc = 1;
      if (acc && mem_rd && !mem_stall) begin
        beats++;
        lastAddr = mem_addr;
      end
      if (acc && cyc > 0 && done[v.who]) lat = cyc;
      @(posedge clk); #1;
      if (acc) req_valid[v.who] = 1'b0;
      mem_stall = 1'b0;
      if (v.stallBeat >= 0 && beats == v.stallBeat && stallUsed < v.stallCycles) begin
        mem_stall = 1'b1;
        stallUsed++;
      end
    end
    mem_stall = 1'b0;
    req_valid = 2'b00;
  endtask

  task automatic waitIdle();
    bit idle;
    idle = 0;
    for (int c = 0; c < 40 && !idle; c++) begin
      @(negedge clk);
      if (!busy && !rd_valid && done == 2'b00) idle = 1;
      @(posedge clk); #1;
    end
    checkOutput("idle_wait", busy, 1'b0);
  endtask

  initial begin
    int          grants[4];
    int          n;
    int          seen;
    int          beats;
    int          lat;
    logic [31:0] lastAddr;

    vecs[0] = '{0, 32'h0000_0100, 4, -1, 0, 32'h0000_0103, 4, 5};
    vecs[1] = '{1, 32'hFFFF_FFFE, 3, -1, 0, 32'h0000_0000, 3, 4};
    vecs[2] = '{0, 32'h0000_2000, 5,  1, 3, 32'h0000_2004, 5, 9};
    vecs[3] = '{0, 32'h0000_0007, 1, -1, 0, 32'h0000_0007, 1, 2};
    vecs[4] = '{1, 32'h0000_0040, 0, -1, 0, 32'h0000_0000, 0, 1};

    rst = 1'b0; req_valid = 2'b00; req_base = '0; req_len = '0; mem_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Both requesters always pending: grants must alternate starting at 0.
    for (int i = 0; i < 4; i++) grants[i] = -1;
    setReq(0, 32'h0000_1000, 2);
    setReq(1, 32'h0000_2000, 2);
    req_valid = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (req_ready != 2'b00) begin
        grants[n] = req_ready[1] ? 1 : 0;
        n++;
      end
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    checkOutput("alt_count", n, 4);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("alt_grant%0d", i), grants[i], i % 2);
    waitIdle();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], beats, lastAddr, lat);
      checkOutput($sformatf("vec%0d_beats", i), beats, vecs[i].expBeats);
      checkOutput($sformatf("vec%0d_last_addr", i), lastAddr, vecs[i].expLast);
      checkOutput($sformatf("vec%0d_done_lat", i), lat, vecs[i].expLat);
      waitIdle();
    end

    // The empty burst from requester 1 must have moved the pointer to 0.
    setReq(0, 32'h0, 0);
    setReq(1, 32'h0, 0);
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("rr_after_zero_len", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitIdle();

    // Reset in the middle of a six-beat burst owned by requester 0.
    setReq(0, 32'h0000_0500, 6);
    req_valid = 2'b01;
    seen = 0;
    for (int c = 0; c < 20 && seen < 2; c++) begin
      @(negedge clk);
      if (mem_rd) seen++;
      @(posedge clk); #1;
      if (busy) req_valid = 2'b00;
    end
    checkOutput("midburst_reached", seen, 2);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    setReq(0, 32'h0000_0600, 1);
    setReq(1, 32'h0000_0700, 1);
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("rr_after_reset", req_ready, 2'b01);
    checkOutput("rst_no_done", done, 2'b00);
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitIdle();

    // Random traffic, lengths, bases and stalls against the model.
    for (int c = 0; c < 400; c++) begin
      setReq(0, ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom(), $urandom_range(0, 4));
      setReq(1, $urandom(), $urandom_range(0, 4));
      req_valid = 2'($urandom_range(0, 3));
      mem_stall = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    req_valid = 2'b00;
    mem_stall = 1'b0;
    waitIdle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vec_rd_scheduler.md
# vec_rd_scheduler

Read-port scheduler for the vector memory. Arbitrates burst read requests from NREQ requesters (vector load unit, operand prefetch) with round-robin priority, then sequences the granted burst by stepping a word address from base for len beats, tagging each returned beat with owner and last flag. Sits between the requesters and the single synchronous-read vector memory port.

## Interface
- NREQ, 2, number of requesters (≥2)
- AW, 32, word-address width
- LW, 8, burst-length width (beats)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  request pending per requester
- req_base  in  NREQ×AW  start word address per requester
- req_len  in  NREQ×LW  beat count per requester; 0 = empty burst
- req_ready  out  NREQ  one-hot accept; handshake = req_valid[i] & req_ready[i]
- mem_rd  out  1  read strobe to memory
- mem_addr  out  AW  read word address
- mem_stall  in  1  memory cannot take a read this cycle
- rd_valid  out  1  memory data valid this cycle (1 cycle after issued beat)
- rd_owner  out  $clog2(NREQ)  requester owning rd_valid beat
- rd_last  out  1  final beat of burst
- done  out  NREQ  one-cycle completion pulse per requester
- busy  out  1  state != IDLE

## Operation
- States: IDLE, BURST.
- IDLE: grant = first req_valid[i] at or after rr_ptr (cyclic). req_ready[grant]=1, others 0; all 0 if no valid. req_ready never asserted outside IDLE.
- Accept with len>0: latch base, len, owner; → BURST. rr_ptr ← owner+1 mod NREQ.
- Accept with len=0: stay IDLE, no memory access, no rd_valid; done[owner] pulses next cycle; rr_ptr updates as above.
- BURST: mem_rd=1, mem_addr=current address. Beat issued when mem_rd & !mem_stall. On issue: address +1 (wraps mod 2^AW), remaining −1. Stall holds address and remaining.
- Issue of last beat (remaining==1) → IDLE next cycle.
- Return tagging: rd_valid, rd_owner, rd_last registered from issue cycle; rd_last=1 only for final beat; done[owner] pulses same cycle as rd_last.
- mem_stall ignored in IDLE.
- Reset (any time, incl. mid-burst): asynchronously state=IDLE, rr_ptr=0, all outputs 0 (mem_addr=0, rd_owner=0); in-flight burst dropped, no done pulse.

## Timing
- Accept at cycle t → first mem_rd at t+1 with mem_addr=base → first rd_valid at t+2.
- No stalls: beats issued t+1..t+len; rd_valid t+2..t+len+1; rd_last & done at t+len+1; state IDLE at t+len+1, so next accept earliest t+len+1 (overlaps final rd_valid).
- Each stalled cycle delays all subsequent beats by 1.
- len=0: done at t+1; next accept possible at t+1.
- Max burst 2^LW−1 beats; remaining counter is LW bits, address counter AW bits.
- All outputs registered except req_ready (combinational from state, req_valid, rr_ptr) and mem_addr (register output direct).

## Structure
- Package vec_rd_pkg: state_t enum {IDLE, BURST}; default AW/LW constants; owner-id width function.
- Sub-module burst_counter: AW-bit loadable up-counter (load, load_val, en, out), asynchronous active-low reset to 0; instanced for mem_addr. Remaining-beat down-count and round-robin pointer stay in the top.

## Test plan
- Single request req0 base=0x100 len=4, no stall → mem_addr 0x100..0x103 on 4 consecutive cycles; rd_valid 4 cycles, owner 0, rd_last and done[0] on 4th.
- Both valid continuously, len=2 each, after reset → grants alternate 0,1,0,1; never two req_ready bits high; no grant while busy.
- Burst base=0xFFFF_FFFE len=3 → addresses 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- len=5 with mem_stall high on 2nd beat for 3 cycles → mem_addr held base+1 for 4 cycles; exactly 5 rd_valid, done 3 cycles later than unstalled.
- req1 len=0 → accepted, done[1] next cycle, no mem_rd, no rd_valid; rr_ptr advances to 0.
- rst low mid-burst (beat 2 of 6) → same-cycle outputs 0, no done; after release req accepted normally from rr_ptr=0.
